// File: rtl/pipeline_ctrl.sv
// Hazard and sequencing controller for a five-stage pipeline: drives pipe register
// enable/flush pairs and the PC enable, and keeps saturating stall/flush counters.
module pipeline_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_dREN,
   input  logic             mem_dWEN,
   input  logic             ex_dREN,
   input  logic [4:0]       ex_wsel,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             ex_redirect,
   input  logic             wb_halt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             exmem_flush,
   output logic             memwb_en,
   output logic             memwb_flush,
   output logic             halt,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam logic [1:0] S_RUN    = 2'd0;
   localparam logic [1:0] S_DWAIT  = 2'd1;
   localparam logic [1:0] S_HALTED = 2'd2;

   logic [1:0]       state_reg, state_next;
   logic             halt_reg;
   logic             dbusy, load_use;
   logic [1:0]       cnt_inc;
   logic [CNT_W-1:0] cnt_reg [0:1];

   assign dbusy    = (mem_dREN | mem_dWEN) & ~dhit;
   assign load_use = ex_dREN & (ex_wsel != 5'd0) &
                     ((ex_wsel == id_rs) | (id_uses_rt & (ex_wsel == id_rt)));

   always_comb begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      ifid_flush  = 1'b0;
      idex_en     = 1'b0;
      idex_flush  = 1'b0;
      exmem_en    = 1'b0;
      exmem_flush = 1'b0;
      memwb_en    = 1'b0;
      memwb_flush = 1'b0;
      cnt_inc     = 2'b00;
      state_next  = state_reg;
      if (RST) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         memwb_flush = 1'b1;
         state_next  = S_RUN;
      end else if (state_reg != S_HALTED) begin
         // A pending data access freezes everything upstream, including a held redirect.
         if (dbusy) begin
            memwb_en    = 1'b1;
            memwb_flush = 1'b1;
            cnt_inc[0]  = 1'b1;
         end else if (ex_redirect) begin
            pc_en      = 1'b1;
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            cnt_inc[1] = 1'b1;
         end else if (load_use) begin
            idex_flush = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            cnt_inc[0] = 1'b1;
         end else if (!ihit) begin
            ifid_en    = 1'b1;
            ifid_flush = 1'b1;
            idex_en    = 1'b1;
            exmem_en   = 1'b1;
            memwb_en   = 1'b1;
            cnt_inc[0] = 1'b1;
         end else begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
         end
         if (dbusy)
            state_next = S_DWAIT;
         else if (wb_halt)
            state_next = S_HALTED;
         else
            state_next = S_RUN;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_reg <= S_RUN;
         halt_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         halt_reg  <= (state_next == S_HALTED);
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
         always_ff @(posedge CLK) begin
            if (RST)
               cnt_reg[gi] <= '0;
            else if (cnt_inc[gi] && (cnt_reg[gi] != {CNT_W{1'b1}}))
               cnt_reg[gi] <= cnt_reg[gi] + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   endgenerate

   assign halt      = halt_reg;
   assign stall_cnt = cnt_reg[0];
   assign flush_cnt = cnt_reg[1];

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl: table of single-cycle vectors plus
// hand-written multi-cycle sequences (reset, data wait, halt, saturation).
module tb_pipeline_ctrl;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ihit, dhit, mem_dREN, mem_dWEN, ex_dREN;
   logic [4:0]  ex_wsel, id_rs, id_rt;
   logic        id_uses_rt, ex_redirect, wb_halt;
   logic        pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
   logic        exmem_en, exmem_flush, memwb_en, memwb_flush, halt;
   logic [15:0] stall_cnt, flush_cnt;
   logic        pc_en4, ifid_en4, ifid_flush4, idex_en4, idex_flush4;
   logic        exmem_en4, exmem_flush4, memwb_en4, memwb_flush4, halt4;
   logic [3:0]  stall_cnt4, flush_cnt4;
   logic [8:0]  ctl;

   int total = 0;
   int bad   = 0;
   int exp_stall = 0;
   int exp_flush = 0;

   // ctl = {pc, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en, memwb_fl}
   localparam logic [8:0] CTL_RUN  = 9'b110101010;
   localparam logic [8:0] CTL_MISS = 9'b011101010;
   localparam logic [8:0] CTL_LU   = 9'b000011010;
   localparam logic [8:0] CTL_RD   = 9'b101011010;
   localparam logic [8:0] CTL_DB   = 9'b000000011;
   localparam logic [8:0] CTL_RST  = 9'b001010101;
   localparam logic [8:0] CTL_OFF  = 9'b000000000;

   always #5 CLK = ~CLK;

   pipeline_ctrl #(.CNT_W(16)) dut (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN),
      .mem_dWEN(mem_dWEN), .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .id_rs(id_rs),
      .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_redirect(ex_redirect),
      .wb_halt(wb_halt), .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_en(idex_en), .idex_flush(idex_flush), .exmem_en(exmem_en),
      .exmem_flush(exmem_flush), .memwb_en(memwb_en), .memwb_flush(memwb_flush),
      .halt(halt), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipeline_ctrl #(.CNT_W(4)) dut4 (
      .CLK(CLK), .RST(RST), .ihit(ihit), .dhit(dhit), .mem_dREN(mem_dREN),
      .mem_dWEN(mem_dWEN), .ex_dREN(ex_dREN), .ex_wsel(ex_wsel), .id_rs(id_rs),
      .id_rt(id_rt), .id_uses_rt(id_uses_rt), .ex_redirect(ex_redirect),
      .wb_halt(wb_halt), .pc_en(pc_en4), .ifid_en(ifid_en4), .ifid_flush(ifid_flush4),
      .idex_en(idex_en4), .idex_flush(idex_flush4), .exmem_en(exmem_en4),
      .exmem_flush(exmem_flush4), .memwb_en(memwb_en4), .memwb_flush(memwb_flush4),
      .halt(halt4), .stall_cnt(stall_cnt4), .flush_cnt(flush_cnt4)
   );

   assign ctl = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                 exmem_en, exmem_flush, memwb_en, memwb_flush};

   typedef struct {
      string      name;
      logic       ih, dh, mr, mw, exr;
      logic [4:0] ws, rs, rt;
      logic       urt, red;
      logic [8:0] exp_ctl;
      int         si, fi;
   } vec_t;

   vec_t vecs [13];

   function automatic vec_t mk(string n, logic ih, logic dh, logic mr, logic mw,
                               logic exr, logic [4:0] ws, logic [4:0] rs, logic [4:0] rt,
                               logic urt, logic red, logic [8:0] c, int si, int fi);
      vec_t v;
      v.name = n; v.ih = ih; v.dh = dh; v.mr = mr; v.mw = mw; v.exr = exr;
      v.ws = ws; v.rs = rs; v.rt = rt; v.urt = urt; v.red = red;
      v.exp_ctl = c; v.si = si; v.fi = fi;
      return v;
   endfunction

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end else begin
         $display("ok   %s: %0h", nm, act);
      end
   endtask

   task automatic drive(logic ih, logic dh, logic mr, logic mw, logic exr,
                        logic [4:0] ws, logic [4:0] rs, logic [4:0] rt,
                        logic urt, logic red, logic wh);
      ihit = ih; dhit = dh; mem_dREN = mr; mem_dWEN = mw; ex_dREN = exr;
      ex_wsel = ws; id_rs = rs; id_rt = rt; id_uses_rt = urt;
      ex_redirect = red; wb_halt = wh;
   endtask

   task automatic idle();
      drive(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
   endtask

   // Advance one clock and land 1 time unit after the edge.
   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic check_cnts(string nm);
      check({nm, " stall_cnt"}, {16'd0, stall_cnt}, exp_stall);
      check({nm, " flush_cnt"}, {16'd0, flush_cnt}, exp_flush);
   endtask

   task automatic do_reset();
      RST = 1'b1;
      idle();
      for (int i = 0; i < 2; i++) begin
         #2;
         check("reset ctl", {23'd0, ctl}, {23'd0, CTL_RST});
         tick();
      end
      RST = 1'b0;
      exp_stall = 0;
      exp_flush = 0;
   endtask

   initial begin
      vecs[0]  = mk("run",          1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, CTL_RUN,  0, 0);
      vecs[1]  = mk("imiss",        0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, CTL_MISS, 1, 0);
      vecs[2]  = mk("lu_rs",        1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0, 0, 0, CTL_LU,   1, 0);
      vecs[3]  = mk("rt_unused",    1, 0, 0, 0, 1, 5'd5, 5'd3, 5'd5, 0, 0, CTL_RUN,  0, 0);
      vecs[4]  = mk("lu_rt",        1, 0, 0, 0, 1, 5'd5, 5'd3, 5'd5, 1, 0, CTL_LU,   1, 0);
      vecs[5]  = mk("wsel0",        1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 0, CTL_RUN,  0, 0);
      vecs[6]  = mk("redir_imiss",  0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, CTL_RD,   0, 1);
      vecs[7]  = mk("redir_lu",     1, 0, 0, 0, 1, 5'd7, 5'd7, 5'd0, 0, 1, CTL_RD,   0, 1);
      vecs[8]  = mk("dbusy_wr",     1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, CTL_DB,   1, 0);
      vecs[9]  = mk("dhit_rd",      1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, CTL_RUN,  0, 0);
      vecs[10] = mk("dbusy_redir",  1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, CTL_DB,   1, 0);
      vecs[11] = mk("no_load",      1, 0, 0, 0, 0, 5'd9, 5'd9, 5'd9, 1, 0, CTL_RUN,  0, 0);
      vecs[12] = mk("dhit_noreq",   1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, CTL_RUN,  0, 0);

      RST = 1'b1;
      idle();
      #1;
      do_reset();
      #2;
      check("post-reset ctl", {23'd0, ctl}, {23'd0, CTL_RUN});
      check("post-reset halt", {31'd0, halt}, 32'd0);
      check_cnts("post-reset");
      tick();

      foreach (vecs[k]) begin
         drive(vecs[k].ih, vecs[k].dh, vecs[k].mr, vecs[k].mw, vecs[k].exr,
               vecs[k].ws, vecs[k].rs, vecs[k].rt, vecs[k].urt, vecs[k].red, 0);
         #2;
         check({vecs[k].name, " ctl"}, {23'd0, ctl}, {23'd0, vecs[k].exp_ctl});
         tick();
         exp_stall += vecs[k].si;
         exp_flush += vecs[k].fi;
         check_cnts(vecs[k].name);
      end

      // Load-use lasts one cycle: the bubble in EX clears ex_dREN
      drive(1, 0, 0, 0, 1, 5'd4, 5'd4, 5'd0, 0, 0, 0);
      #2; check("lu1 ctl", {23'd0, ctl}, {23'd0, CTL_LU});
      tick(); exp_stall++;
      drive(1, 0, 0, 0, 0, 5'd0, 5'd4, 5'd0, 0, 0, 0);
      #2; check("lu2 ctl", {23'd0, ctl}, {23'd0, CTL_RUN});
      tick();
      check_cnts("lu seq");

      // Three-cycle data wait, released on dhit
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
         #2; check("dwait ctl", {23'd0, ctl}, {23'd0, CTL_DB});
         tick(); exp_stall++;
      end
      drive(1, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
      #2; check("dwait release ctl", {23'd0, ctl}, {23'd0, CTL_RUN});
      tick();
      check_cnts("dwait seq");

      // Redirect held under dbusy, taken on the dhit cycle
      drive(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
      #2; check("held redir ctl", {23'd0, ctl}, {23'd0, CTL_DB});
      tick(); exp_stall++;
      drive(0, 1, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0);
      #2; check("taken redir ctl", {23'd0, ctl}, {23'd0, CTL_RD});
      tick(); exp_flush++;
      check_cnts("redir seq");

      // wb_halt is ignored while the data access is still busy
      drive(1, 0, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
      #2; check("halt under dbusy ctl", {23'd0, ctl}, {23'd0, CTL_DB});
      tick(); exp_stall++;
      check("halt under dbusy", {31'd0, halt}, 32'd0);
      drive(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1);
      #2; check("halt entry ctl", {23'd0, ctl}, {23'd0, CTL_RUN});
      check("halt entry halt", {31'd0, halt}, 32'd0);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(i[0], i[1], i[0], 0, 1, 5'd2, 5'd2, 5'd0, 0, i[1], 0);
         #2;
         check("halted halt", {31'd0, halt}, 32'd1);
         check("halted ctl", {23'd0, ctl}, {23'd0, CTL_OFF});
         tick();
      end
      check_cnts("halted");

      do_reset();
      #2;
      check("halt cleared", {31'd0, halt}, 32'd0);
      check("after halt ctl", {23'd0, ctl}, {23'd0, CTL_RUN});
      check_cnts("after halt reset");
      tick();

      // Saturation: 20 fetch misses against a 4-bit counter instance
      for (int i = 0; i < 20; i++) begin
         drive(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0);
         tick(); exp_stall++;
      end
      check("sat stall_cnt16", {16'd0, stall_cnt}, exp_stall);
      check("sat stall_cnt4", {28'd0, stall_cnt4}, 32'd15);
      check("sat halt4", {31'd0, halt4}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
